// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: shares one Wishbone bus between N masters, fixed-priority 0 then round-robin 1..N-1,
// with a no-ACK watchdog that errors and drains a stuck cycle.
module wb_bus_arbiter #(
  parameter int N              = 3,
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clock_i,
  input  logic                       reset_ni,
  input  logic [N-1:0]               req_cyc_i,
  input  logic [N-1:0]               req_stb_i,
  input  logic [N-1:0]               req_we_i,
  input  logic [N*ADDR_WIDTH-1:0]    req_adr_i,
  input  logic [N*DATA_WIDTH-1:0]    req_dat_i,
  output logic [N-1:0]               req_ack_o,
  output logic [N-1:0]               req_err_o,
  output logic [N-1:0]               req_stall_o,
  output logic [DATA_WIDTH-1:0]      req_dat_o,
  output logic [N-1:0]               grant_o,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic                       wb_we_o,
  output logic [ADDR_WIDTH-1:0]      wb_adr_o,
  output logic [DATA_WIDTH-1:0]      wb_dat_o,
  input  logic [DATA_WIDTH-1:0]      wb_dat_i,
  input  logic                       wb_ack_i,
  input  logic                       wb_stall_i
);
  localparam int IW = $clog2(N);
  localparam int WW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          busy, timeout, found;
  int            win;

  assign busy    = state_q == BUSY;
  assign timeout = TIMEOUT_CYCLES != 0 && busy && !wb_ack_i && wd_q == WW'(TIMEOUT_CYCLES);

  // Requester 0 always wins; otherwise search upward from the pointer, wrapping within 1..N-1.
  always_comb begin
    found = req_cyc_i[0];
    win   = 0;
    for (int j = 0; j < N - 1; j++)
      if (!found && req_cyc_i[(int'(ptr_q) - 1 + j) % (N - 1) + 1]) begin
        found = 1'b1;
        win   = (int'(ptr_q) - 1 + j) % (N - 1) + 1;
      end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    wd_d    = busy ? (wb_ack_i ? '0 : (&wd_q ? wd_q : wd_q + 1'b1)) : '0;
    case (state_q)
      IDLE:
        if (found) begin
          state_d = BUSY;
          grant_d = N'(1) << win;
          idx_d   = IW'(win);
          if (win != 0) ptr_d = win == N - 1 ? IW'(1) : IW'(win + 1);
        end
      BUSY:
        if (!req_cyc_i[idx_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (timeout) state_d = DRAIN;
      DRAIN:
        if (!req_cyc_i[idx_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end

  // Master side follows the granted requester only while BUSY; IDLE and DRAIN park it at zero.
  assign wb_cyc_o    = busy & req_cyc_i[idx_q];
  assign wb_stb_o    = busy & req_stb_i[idx_q];
  assign wb_we_o     = busy & req_we_i[idx_q];
  assign wb_adr_o    = busy ? req_adr_i[idx_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign wb_dat_o    = busy ? req_dat_i[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign req_ack_o   = busy ? grant_q & {N{wb_ack_i}} : '0;
  assign req_stall_o = busy ? ~grant_q | {N{wb_stall_i}} : '1;
  assign req_err_o   = timeout ? grant_q : '0;
  assign req_dat_o   = wb_dat_i;
  assign grant_o     = grant_q;
endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares the single 20-bit Wishbone bus (RAM, registers, CRTC, keyboard windows) between N pipelined masters: video fetch, 6502 CPU bridge, SPI/MCU bridge.
- Requester 0 has fixed highest priority. Requesters 1..N-1 rotate round-robin.
- A grant is held for the whole Wishbone cycle (CYC high).
- A watchdog terminates cycles that receive no ACK from the slave.

Parameters:
- N, 3: number of requesters (2..8). Index 0 = video, 1 = CPU, 2 = SPI.
- ADDR_WIDTH, 20: Wishbone address width (WB_ADDR_WIDTH).
- DATA_WIDTH, 8: Wishbone data width.
- TIMEOUT_CYCLES, 64: clocks without ACK before the cycle is aborted. 0 disables the watchdog.

Ports:
- clock_i  in  1  system clock (64 MHz)
- reset_ni  in  1  asynchronous, active-low reset
- req_cyc_i  in  N  per-requester CYC
- req_stb_i  in  N  per-requester STB
- req_we_i  in  N  per-requester WE
- req_adr_i  in  N*ADDR_WIDTH  addresses; requester k occupies [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_dat_i  in  N*DATA_WIDTH  write data, packed the same way
- req_ack_o  out  N  ACK routed to the granted requester only
- req_err_o  out  N  one-cycle timeout error pulse to the granted requester
- req_stall_o  out  N  STALL; 1 for every non-granted requester
- req_dat_o  out  DATA_WIDTH  read data, wb_dat_i broadcast to all requesters
- grant_o  out  N  one-hot current grant, all zero when idle
- wb_cyc_o  out  1  master-side CYC
- wb_stb_o  out  1  master-side STB
- wb_we_o  out  1  master-side WE
- wb_adr_o  out  ADDR_WIDTH  master-side address
- wb_dat_o  out  DATA_WIDTH  master-side write data
- wb_dat_i  in  DATA_WIDTH  slave read data
- wb_ack_i  in  1  slave ACK
- wb_stall_i  in  1  slave STALL

Behaviour:
- Reset (async, reset_ni=0):
  - state=IDLE, grant_o=0, round-robin pointer=1, watchdog=0.
  - wb_cyc_o, wb_stb_o, wb_we_o = 0. wb_adr_o, wb_dat_o = 0.
  - req_ack_o=0, req_err_o=0, req_stall_o = all ones.
  - Reset asserted mid-cycle aborts immediately. No ACK or ERR is issued.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - Master outputs are 0. All req_stall_o=1.
  - Arbitration (registered): if req_cyc_i[0], winner=0. Otherwise winner is the first requester k with req_cyc_i[k]=1, searching upward from the pointer and wrapping within 1..N-1.
  - Winner is registered into grant_o. State goes to BUSY next cycle.
  - Latency: req_cyc_i rising at edge T gives grant_o and wb_cyc_o high after edge T+1.
  - The pointer is updated to winner+1 (wrapping to 1 after N-1) only when the winner is nonzero.
- BUSY, granted index g, master side combinational from requester g:
  - wb_cyc_o = req_cyc_i[g], wb_stb_o = req_stb_i[g], wb_we_o = req_we_i[g].
  - wb_adr_o and wb_dat_o = slice g of req_adr_i / req_dat_i.
  - req_stall_o[g] = wb_stall_i. req_ack_o[g] = wb_ack_i. All other requesters: ACK=0, STALL=1.
  - Higher-priority requests never pre-empt an active grant.
- BUSY exit and watchdog:
  - req_cyc_i[g] falls: registered transition to IDLE, grant_o clears. This leaves exactly one idle cycle between grants, so there are no back-to-back grants.
  - Watchdog counts clocks in BUSY. It clears on grant entry and on every wb_ack_i.
  - When it reaches TIMEOUT_CYCLES (nonzero):
    - req_err_o[g]=1 for exactly one cycle.
    - State goes to DRAIN. wb_cyc_o and wb_stb_o forced 0 from the next cycle.
  - If wb_ack_i and timeout coincide, ACK wins: counter clears, no ERR.
- DRAIN:
  - Master outputs 0. req_stall_o[g]=1. wb_ack_i is ignored (not forwarded).
  - Stays in DRAIN until req_cyc_i[g]=0, then goes to IDLE. grant_o stays g during DRAIN.
- Watchdog width is bit_width(TIMEOUT_CYCLES). The counter saturates and never wraps.
- Requester CYC dropping in the same cycle it would be granted: the grant is still registered, then BUSY sees cyc=0 and returns to IDLE. Net effect is one wasted cycle, with no master STB.

Test Plan:
1. Reset, then all req_cyc_i=0 for 10 cycles -> grant_o=0, wb_cyc_o=0, req_stall_o=3'b111 throughout.
2. CPU (1) single read, addr 20'h08000, slave ACKs with data 8'h41 after 2 cycles -> grant_o=3'b010 one cycle after request; req_ack_o[1] pulses; req_dat_o=8'h41; grant clears one cycle after CPU drops CYC.
3. Requesters 1 and 2 hold CYC continuously, each releasing after one transfer and re-requesting -> grants alternate 1,2,1,2 with one idle cycle between each; video asserting CYC during a CPU grant waits, then wins the next arbitration over both.
4. Video (0) pipelined burst of 4 STBs with wb_stall_i high on the 2nd -> exactly 4 master STBs accepted in order; req_stall_o[0] mirrors wb_stall_i; req_stall_o[1]=req_stall_o[2]=1.
5. TIMEOUT_CYCLES=64, SPI granted, slave never ACKs -> req_err_o[2] single pulse 64 cycles after grant; wb_cyc_o=0 next cycle; grant held until req_cyc_i[2]=0.
6. Variants:
   - wb_ack_i on the exact timeout cycle -> ACK delivered, no ERR, cycle continues.
   - reset_ni low mid-BUSY -> all outputs at reset values asynchronously; no ACK or ERR.
